// File: rtl/asyn_fifo_pkg.sv
// Shared helpers for the async FIFO write-side pointer logic: Gray/binary
// conversion, multi-bit-change detection and the legal synchroniser depth range.
package asyn_fifo_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int PTR_MAX_W       = 32;

  // Zero-extended Gray input converts correctly because leading zeros add nothing to the XOR prefix.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic popcount_gt1(input logic [PTR_MAX_W-1:0] x);
    return (x & (x - PTR_MAX_W'(1))) != '0;
  endfunction

endpackage

// File: rtl/asyn_fifo_sync_chain.sv
// Single-channel WIDTH x STAGES synchroniser flop chain, no logic between stages.
module asyn_fifo_sync_chain #(
  parameter int WIDTH  = 7,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/asyn_fifo_ptr_sync_multi.sv
// Multi-channel read-to-write Gray pointer synchroniser with free-space/full logic.
// Optional sticky Gray-violation check enabled by ASYN_FIFO_PTR_GRAY_CHECK_EN.
module asyn_fifo_ptr_sync_multi
  import asyn_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 6,
  parameter int SYNC_STAGES = 2,
  parameter int CHANNELS    = 2
) (
  input  logic                               write_clk,
  input  logic                               write_rst_n,
  input  logic [CHANNELS*(ADDR_WIDTH+1)-1:0] read_ptr,
  input  logic [CHANNELS*(ADDR_WIDTH+1)-1:0] write_ptr_bin,
  input  logic [CHANNELS-1:0]                err_clr,
  output logic [CHANNELS*(ADDR_WIDTH+1)-1:0] sync_read_to_write,
  output logic [CHANNELS*(ADDR_WIDTH+1)-1:0] sync_read_bin,
  output logic [CHANNELS*(ADDR_WIDTH+1)-1:0] free_cnt,
  output logic [CHANNELS-1:0]                full,
  output logic [CHANNELS-1:0]                gray_err
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("asyn_fifo_ptr_sync_multi: SYNC_STAGES must be in 2..4");
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [PW-1:0] sync_g;
    logic [PW-1:0] bin_q;
    logic [PW-1:0] used;

    asyn_fifo_sync_chain #(
      .WIDTH (PW),
      .STAGES(SYNC_STAGES)
    ) u_chain (
      .clk  (write_clk),
      .rst_n(write_rst_n),
      .d    (read_ptr[c*PW +: PW]),
      .q    (sync_g)
    );

    always_ff @(posedge write_clk or negedge write_rst_n) begin
      if (!write_rst_n) bin_q <= '0;
      else              bin_q <= PW'(gray2bin(PTR_MAX_W'(sync_g)));
    end

    // Modulo subtraction hides pointer wrap; used > DEPTH cannot match, so full stays 0 then.
    assign used                       = write_ptr_bin[c*PW +: PW] - bin_q;
    assign free_cnt[c*PW +: PW]       = DEPTH_V - used;
    assign full[c]                    = (used == DEPTH_V);
    assign sync_read_to_write[c*PW +: PW] = sync_g;
    assign sync_read_bin[c*PW +: PW]  = bin_q;

`ifdef ASYN_FIFO_PTR_GRAY_CHECK_EN
    logic [PW-1:0] prev_q;
    logic          err_q;
    logic          viol;

    assign viol = popcount_gt1(PTR_MAX_W'(sync_g ^ prev_q));

    // A fresh violation outranks a clear arriving in the same cycle.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
      if (!write_rst_n) begin
        prev_q <= '0;
        err_q  <= 1'b0;
      end else begin
        prev_q <= sync_g;
        err_q  <= viol | (err_q & ~err_clr[c]);
      end
    end

    assign gray_err[c] = err_q;
`else
    assign gray_err[c] = 1'b0;
`endif
  end

`ifndef ASYN_FIFO_PTR_GRAY_CHECK_EN
  logic unused_err_clr;
  assign unused_err_clr = ^err_clr;
`endif

endmodule

// File: tb/tb_asyn_fifo_ptr_sync_multi.sv
// Directed bench for asyn_fifo_ptr_sync_multi (ADDR_WIDTH=6, SYNC_STAGES=2, CHANNELS=2);
// gray_err expectations follow ASYN_FIFO_PTR_GRAY_CHECK_EN.
module tb_asyn_fifo_ptr_sync_multi;

  localparam int AW = 6;
  localparam int SS = 2;
  localparam int CH = 2;
  localparam int PW = AW + 1;

`ifdef ASYN_FIFO_PTR_GRAY_CHECK_EN
  localparam logic GE = 1'b1;
`else
  localparam logic GE = 1'b0;
`endif

  logic                 write_clk = 1'b0;
  logic                 write_rst_n;
  logic [CH*PW-1:0]     read_ptr;
  logic [CH*PW-1:0]     write_ptr_bin;
  logic [CH-1:0]        err_clr;
  logic [CH*PW-1:0]     sync_read_to_write;
  logic [CH*PW-1:0]     sync_read_bin;
  logic [CH*PW-1:0]     free_cnt;
  logic [CH-1:0]        full;
  logic [CH-1:0]        gray_err;

  int errors = 0;
  int checks = 0;

  asyn_fifo_ptr_sync_multi #(
    .ADDR_WIDTH (AW),
    .SYNC_STAGES(SS),
    .CHANNELS   (CH)
  ) dut (
    .write_clk         (write_clk),
    .write_rst_n       (write_rst_n),
    .read_ptr          (read_ptr),
    .write_ptr_bin     (write_ptr_bin),
    .err_clr           (err_clr),
    .sync_read_to_write(sync_read_to_write),
    .sync_read_bin     (sync_read_bin),
    .free_cnt          (free_cnt),
    .full              (full),
    .gray_err          (gray_err)
  );

  always #5 write_clk = ~write_clk;

  function automatic logic [PW-1:0] syncOf(input int c);
    return sync_read_to_write[c*PW +: PW];
  endfunction

  function automatic logic [PW-1:0] binOf(input int c);
    return sync_read_bin[c*PW +: PW];
  endfunction

  function automatic logic [PW-1:0] freeOf(input int c);
    return free_cnt[c*PW +: PW];
  endfunction

  task automatic applyStimulus(input int c, input logic [PW-1:0] rp, input logic [PW-1:0] wp);
    read_ptr[c*PW +: PW]      = rp;
    write_ptr_bin[c*PW +: PW] = wp;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge write_clk);
    #1;
  endtask

  initial begin
    write_rst_n   = 1'b0;
    read_ptr      = '0;
    write_ptr_bin = '0;
    err_clr       = '0;
    #3;
    checkOutput("rst_sync", 32'(sync_read_to_write), 0);
    checkOutput("rst_bin", 32'(sync_read_bin), 0);
    checkOutput("rst_err", 32'(gray_err), 0);
    #4 write_rst_n = 1'b1;
    tick(3);
    checkOutput("idle_free0", 32'(freeOf(0)), 64);
    checkOutput("idle_free1", 32'(freeOf(1)), 64);
    checkOutput("idle_full", 32'(full), 0);
    checkOutput("idle_err", 32'(gray_err), 0);

    $display("[TB] ch0 Gray step 0->1");
    applyStimulus(0, 7'd1, 7'd1);
    tick(1);
    checkOutput("step_sync_e1", 32'(syncOf(0)), 0);
    tick(1);
    checkOutput("step_sync_e2", 32'(syncOf(0)), 1);
    checkOutput("step_bin_e2", 32'(binOf(0)), 0);
    tick(1);
    checkOutput("step_bin_e3", 32'(binOf(0)), 1);
    checkOutput("step_free0", 32'(freeOf(0)), 64);
    checkOutput("step_ch1_sync", 32'(syncOf(1)), 0);
    checkOutput("step_ch1_bin", 32'(binOf(1)), 0);

    $display("[TB] ch1 full then release");
    applyStimulus(1, 7'd0, 7'd64);
    #1;
    checkOutput("full_comb", 32'(full[1]), 1);
    checkOutput("full_free", 32'(freeOf(1)), 0);
    tick(1);
    applyStimulus(1, 7'd1, 7'd64);
    tick(2);
    checkOutput("full_hold_e2", 32'(full[1]), 1);
    tick(1);
    checkOutput("full_clear_e3", 32'(full[1]), 0);
    checkOutput("full_free_e3", 32'(freeOf(1)), 1);

    $display("[TB] ch0 wrap");
    applyStimulus(0, 7'b1000000, 7'd3);
    tick(3);
    checkOutput("wrap_bin", 32'(binOf(0)), 127);
    checkOutput("wrap_free", 32'(freeOf(0)), 60);
    checkOutput("wrap_full", 32'(full[0]), 0);
    checkOutput("wrap_err", 32'(gray_err[0]), 32'(GE));

    $display("[TB] Gray check");
    err_clr[0] = 1'b1;
    tick(1);
    err_clr[0] = 1'b0;
    checkOutput("clr_after_wrap", 32'(gray_err[0]), 0);
    applyStimulus(0, 7'd0, 7'd0);
    tick(3);
    checkOutput("single_bit_ok", 32'(gray_err[0]), 0);
    applyStimulus(0, 7'd3, 7'd2);
    tick(2);
    checkOutput("viol_e2", 32'(gray_err[0]), 0);
    tick(1);
    checkOutput("viol_e3", 32'(gray_err[0]), 32'(GE));
    err_clr[0] = 1'b1;
    tick(1);
    err_clr[0] = 1'b0;
    checkOutput("viol_clr", 32'(gray_err[0]), 0);
    applyStimulus(0, 7'd0, 7'd0);
    tick(2);
    err_clr[0] = 1'b1;
    tick(1);
    err_clr[0] = 1'b0;
    checkOutput("set_wins", 32'(gray_err[0]), 32'(GE));
    tick(1);
    checkOutput("sticky", 32'(gray_err[0]), 32'(GE));
    checkOutput("ch1_err", 32'(gray_err[1]), 0);

    $display("[TB] mid-stream reset");
    applyStimulus(0, 7'd5, 7'd6);
    tick(3);
    checkOutput("pre_rst_bin", 32'(binOf(0)), 6);
    #2 write_rst_n = 1'b0;
    #1;
    checkOutput("arst_sync", 32'(sync_read_to_write), 0);
    checkOutput("arst_bin", 32'(sync_read_bin), 0);
    checkOutput("arst_err", 32'(gray_err), 0);
    #1 write_rst_n = 1'b1;
    tick(2);
    checkOutput("rel_sync_e2", 32'(syncOf(0)), 5);
    checkOutput("rel_bin_e2", 32'(binOf(0)), 0);
    tick(1);
    checkOutput("rel_bin_e3", 32'(binOf(0)), 6);
    checkOutput("rel_free_e3", 32'(freeOf(0)), 64);
    checkOutput("rel_err_e3", 32'(gray_err[0]), 32'(GE));
    checkOutput("rel_ch1_bin", 32'(binOf(1)), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
